// File: rtl/pwm_audio_multi_out.sv
// pwm_audio_multi_out: FIFO-buffered multi-channel PCM to per-channel PWM with underrun statistics
module pwm_audio_multi_out #(
  parameter int CHANNELS      = 2,
  parameter int SAMPLE_BITS   = 8,
  parameter int SUBSAMPLES    = 10,
  parameter int DEPTH         = 8,
  parameter int SIGNED_IN     = 0,
  parameter int UNDERRUN_HOLD = 0
) (
  input  logic                            clk_audio,
  input  logic                            aclr_n,
  input  logic                            enable,
  input  logic [CHANNELS*SAMPLE_BITS-1:0] in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [CHANNELS-1:0]             pwm_out,
  output logic [$clog2(DEPTH+1)-1:0]      fifo_level,
  output logic                            sample_tick,
  output logic                            underrun,
  output logic [15:0]                     underrun_count
);
  localparam int FW = CHANNELS * SAMPLE_BITS;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int SW = SUBSAMPLES > 1 ? $clog2(SUBSAMPLES) : 1;
  logic [SAMPLE_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [SW-1:0]          sub_q, sub_d;
  logic [FW-1:0]          level_q, level_d, conv;
  logic [FW-1:0]          mem_q [DEPTH];
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0]    pwm_q, pwm_d;
  logic [15:0]            ucnt_q, ucnt_d;
  logic                   tick_q, tick_d, ur_q, ur_d;
  logic                   wrap, bnd, push, pop;
  always_comb begin
    in_ready  = cnt_q < LW'(DEPTH);
    push      = in_valid && in_ready;
    wrap      = enable && pwm_cnt_q == '1;
    bnd       = wrap && sub_q == SW'(SUBSAMPLES - 1);
    pop       = bnd && cnt_q != '0;
    tick_d    = pop;
    ur_d      = bnd && cnt_q == '0;
    pwm_cnt_d = enable ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    sub_d     = bnd ? '0 : wrap ? sub_q + 1'b1 : sub_q;
    wr_d      = push ? wr_q + 1'b1 : wr_q;
    rd_d      = pop ? rd_q + 1'b1 : rd_q;
    cnt_d     = cnt_q + LW'(push) - LW'(pop);
    ucnt_d    = (ur_d && ucnt_q != '1) ? ucnt_q + 1'b1 : ucnt_q;
    conv      = mem_q[rd_q];
    for (int c = 0; c < CHANNELS; c++)
      conv[c*SAMPLE_BITS+SAMPLE_BITS-1] = conv[c*SAMPLE_BITS+SAMPLE_BITS-1] ^ (SIGNED_IN != 0);
    level_d   = pop ? conv : (ur_d && UNDERRUN_HOLD == 0) ? '0 : level_q;
    pwm_d     = '0;
    for (int c = 0; c < CHANNELS; c++)
      pwm_d[c] = enable && (pwm_cnt_q < level_q[c*SAMPLE_BITS +: SAMPLE_BITS]);
  end
  always_ff @(posedge clk_audio or negedge aclr_n)
    if (!aclr_n) begin
      pwm_cnt_q <= '0;
      sub_q     <= '0;
      level_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      pwm_q     <= '0;
      ucnt_q    <= '0;
      tick_q    <= 1'b0;
      ur_q      <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      sub_q     <= sub_d;
      level_q   <= level_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_d;
      ucnt_q    <= ucnt_d;
      tick_q    <= tick_d;
      ur_q      <= ur_d;
    end
  always_ff @(posedge clk_audio)
    if (push) mem_q[wr_q] <= in_data;
  assign pwm_out        = pwm_q;
  assign fifo_level     = cnt_q;
  assign sample_tick    = tick_q;
  assign underrun       = ur_q;
  assign underrun_count = ucnt_q;
endmodule

// File: tb/tb_pwm_audio_multi_out.sv
// tb_pwm_audio_multi_out: two configurations (plain/zero-on-underrun, signed/hold) against a phase-based reference model
module tb_pwm_audio_multi_out;
  localparam int SB = 4, SUB = 2, DEPTH = 4, P = 16, PS = P * SUB;
  logic       clk = 0, aclr_n = 1, enable = 0, in_valid = 0;
  logic [7:0] in_data = '0;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  task automatic chk(string name, int g, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cfg%0d: got %0d expected %0d at %0t", name, g, act, exp, $time);
    end
  endtask
  function automatic int conv(int si, logic [7:0] f, int c);
    int v;
    v = int'(f[c*SB +: SB]);
    return si != 0 ? (v + P / 2) % P : v;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int UH = g;
    logic        in_ready, sample_tick, underrun;
    logic [1:0]  pwm_out;
    logic [2:0]  fifo_level;
    logic [15:0] underrun_count;
    pwm_audio_multi_out #(.CHANNELS(2), .SAMPLE_BITS(SB), .SUBSAMPLES(SUB), .DEPTH(DEPTH),
                          .SIGNED_IN(g), .UNDERRUN_HOLD(g)) dut (
      .clk_audio(clk), .aclr_n(aclr_n), .enable(enable), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .pwm_out(pwm_out), .fifo_level(fifo_level),
      .sample_tick(sample_tick), .underrun(underrun), .underrun_count(underrun_count));
    int         phase = 0, ucnt = 0, sz, win = 0;
    int         lvl[2] = '{0, 0}, hc[2] = '{0, 0}, exl[2] = '{0, 0};
    logic [7:0] mq[$], sb[$], f, tf;
    bit  [1:0]  e_pwm = '0;
    bit         e_tick = 0, e_ur = 0, b;
    always @(posedge clk or negedge aclr_n)
      if (!aclr_n) begin
        phase = 0; ucnt = 0; lvl = '{0, 0}; e_pwm = '0; e_tick = 0; e_ur = 0;
        mq.delete(); sb.delete();
      end else begin
        sz = mq.size();
        b = enable && phase == PS - 1;
        for (int c = 0; c < 2; c++) e_pwm[c] = enable && (phase % P) < lvl[c];
        e_tick = b && sz > 0;
        e_ur   = b && sz == 0;
        if (e_tick) begin
          f = mq.pop_front();
          for (int c = 0; c < 2; c++) lvl[c] = conv(g, f, c);
        end
        if (e_ur) begin
          if (ucnt < 65535) ucnt++;
          if (UH == 0) lvl = '{0, 0};
        end
        if (in_valid && sz < DEPTH) begin
          mq.push_back(in_data);
          sb.push_back(in_data);
        end
        if (enable) phase = (phase + 1) % PS;
      end
    always @(negedge clk) begin
      chk("pwm_out", g, int'(pwm_out), int'(e_pwm));
      chk("fifo_level", g, int'(fifo_level), mq.size());
      chk("in_ready", g, int'(in_ready), int'(mq.size() < DEPTH));
      chk("sample_tick", g, int'(sample_tick), int'(e_tick));
      chk("underrun", g, int'(underrun), int'(e_ur));
      chk("underrun_count", g, int'(underrun_count), ucnt);
    end
    always @(negedge clk) begin
      if (!aclr_n || !enable) win = 0;
      else if (win > 0) begin
        for (int c = 0; c < 2; c++) hc[c] += int'(pwm_out[c]);
        win--;
        if (win == 0) begin
          chk("duty_ch0", g, hc[0], exl[0]);
          chk("duty_ch1", g, hc[1], exl[1]);
        end
      end
      if (aclr_n && sample_tick) begin
        chk("tick_has_frame", g, int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          tf = sb.pop_front();
          for (int c = 0; c < 2; c++) exl[c] = conv(g, tf, c);
          hc  = '{0, 0};
          win = enable ? P : 0;
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [7:0] d);
    int n = 0;
    in_data = d;
    in_valid = 1;
    @(negedge clk);
    while (!cfg[0].in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_handshake", 0, int'(n < 200), 1);
    step();
    in_valid = 0;
  endtask
  initial begin
    int n;
    #2 aclr_n = 0;
    repeat (3) step();
    aclr_n = 1;
    step();
    send(8'h3C);
    enable = 1;
    repeat (3 * PS + 4) step();
    enable = 0;
    for (int i = 0; i < 4; i++) send(8'($urandom));
    in_data = 8'($urandom);
    in_valid = 1;
    repeat (2) step();
    enable = 1;
    send(in_data);
    repeat (6 * PS) step();
    send(8'h78);
    repeat (3 * PS) step();
    n = 0;
    while (!(cfg[0].phase == PS - 1 && cfg[0].mq.size() == 0) && n < 200) begin
      step();
      n++;
    end
    chk("b_align", 0, int'(n < 200), 1);
    in_data = 8'($urandom);
    in_valid = 1;
    step();
    in_valid = 0;
    repeat (2 * PS + 4) step();
    for (int i = 0; i < 3; i++) send(8'($urandom));
    repeat (5) step();
    aclr_n = 0;
    repeat (2) step();
    aclr_n = 1;
    repeat (2 * PS + 4) step();
    for (int i = 0; i < 800; i++) begin
      in_valid = $urandom_range(0, 3) == 0;
      in_data  = 8'($urandom);
      enable   = $urandom_range(0, 49) != 0;
      if (i == 400) aclr_n = 0;
      if (i == 403) aclr_n = 1;
      step();
    end
    in_valid = 0;
    enable = 1;
    repeat (3 * PS) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
